// File: rtl/ravenoc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ravenoc_pkg: AXI4 channel structs and machine-timer register map |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ravenoc_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [4:0] MTIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_CTRL        = 5'h10;
  localparam logic [4:0] MTIMER_PRESCALE    = 5'h14;
  localparam logic [4:0] MTIMER_END         = 5'h18;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    axi_resp_t             bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    axi_resp_t             rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic [31:0] prescale;
  } mtimer_regs_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic mtimer_addr_ok(input logic [4:0] off);
    return (off[1:0] == 2'b00) && (off < MTIMER_END);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_slave_if: single-beat AXI4 slave front end for axi_mtimer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_slave_if
  import ravenoc_pkg::*;
(
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic [3:0]  reg_wr_strb,
  output logic [4:0]  reg_rd_addr,
  input  logic [31:0] reg_rd_data
);

  logic                aw_held, aw_err;
  logic [AXI_ID_W-1:0] aw_id;
  logic [4:0]          aw_addr;
  logic                w_held;
  logic [31:0]         w_data;
  logic [3:0]          w_strb;
  logic                bvalid;
  axi_resp_t           bresp;

  logic                rvalid;
  logic [AXI_ID_W-1:0] rid;
  logic [31:0]         rdata;
  axi_resp_t           rresp;
  logic [7:0]          r_beats;

  logic aw_hs, w_hs, b_hs, wr_fire, ar_hs, r_hs;

  assign aw_hs   = axi_mosi.awvalid && !aw_held;
  assign w_hs    = axi_mosi.wvalid && !w_held;
  assign b_hs    = bvalid && axi_mosi.bready;
  assign wr_fire = aw_held && w_held && !bvalid;
  assign ar_hs   = axi_mosi.arvalid && !rvalid;
  assign r_hs    = rvalid && axi_mosi.rready;

  // W beats are drained until wlast; only the final beat is held
  always_ff @(posedge clk) begin
    if (arst) begin
      aw_held <= 1'b0;
      aw_err  <= 1'b0;
      aw_id   <= '0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else if (b_hs) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_id   <= axi_mosi.awid;
        aw_addr <= axi_mosi.awaddr[4:0];
        aw_err  <= (axi_mosi.awlen != 8'd0) || !mtimer_addr_ok(axi_mosi.awaddr[4:0]);
      end
      if (w_hs && axi_mosi.wlast) begin
        w_held <= 1'b1;
        w_data <= axi_mosi.wdata;
        w_strb <= axi_mosi.wstrb;
      end
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= aw_err ? SLVERR : OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= OKAY;
      r_beats <= '0;
    end else if (ar_hs) begin
      rvalid  <= 1'b1;
      rid     <= axi_mosi.arid;
      r_beats <= axi_mosi.arlen;
      if ((axi_mosi.arlen != 8'd0) || !mtimer_addr_ok(axi_mosi.araddr[4:0])) begin
        rresp <= SLVERR;
        rdata <= '0;
      end else begin
        rresp <= OKAY;
        rdata <= reg_rd_data;
      end
    end else if (r_hs) begin
      if (r_beats == 8'd0) rvalid <= 1'b0;
      else r_beats <= r_beats - 8'd1;
    end
  end

  assign reg_wr_en   = wr_fire && !aw_err;
  assign reg_wr_addr = aw_addr;
  assign reg_wr_data = w_data;
  assign reg_wr_strb = w_strb;
  assign reg_rd_addr = axi_mosi.araddr[4:0];

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = !aw_held;
    axi_miso.wready  = !w_held;
    axi_miso.bid     = aw_id;
    axi_miso.bresp   = bresp;
    axi_miso.bvalid  = bvalid;
    axi_miso.arready = !rvalid;
    axi_miso.rid     = rid;
    axi_miso.rdata   = rdata;
    axi_miso.rresp   = rresp;
    axi_miso.rlast   = rvalid && (r_beats == 8'd0);
    axi_miso.rvalid  = rvalid;
  end

  logic unused_bits;
  assign unused_bits = ^{axi_mosi.awaddr[31:5], axi_mosi.awsize, axi_mosi.awburst,
                         axi_mosi.araddr[31:5], axi_mosi.arsize, axi_mosi.arburst};

endmodule
`default_nettype wire

// File: rtl/axi_mtimer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_mtimer: RISC-V machine timer (mtime/mtimecmp) on AXI4        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_mtimer
  import ravenoc_pkg::*;
#(
  parameter int          PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        timer_irq_o
);

  localparam logic [31:0] PRESCALE_MASK = 32'((64'd1 << PRESCALE_W) - 64'd1);

  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;

  mtimer_regs_t          regs, regs_nxt;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  irq;
  logic                  tick, carry;

  axi_slave_if u_axi_slave_if (
    .clk         (clk),
    .arst        (arst),
    .axi_mosi    (axi_mosi),
    .axi_miso    (axi_miso),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data)
  );

  // A software write to one mtime half replaces the ticked value for that
  // half only; a lo->hi carry still lands in an unwritten hi half.
  always_comb begin
    tick     = regs.en && (pcnt == regs.prescale[PRESCALE_W-1:0]);
    carry    = tick && (regs.mtime[31:0] == 32'hFFFF_FFFF);
    regs_nxt = regs;
    regs_nxt.mtime[31:0]  = regs.mtime[31:0] + 32'(tick);
    regs_nxt.mtime[63:32] = regs.mtime[63:32] + 32'(carry);
    if (reg_wr_en) begin
      case (reg_wr_addr)
        MTIMER_MTIME_LO:
          regs_nxt.mtime[31:0] = apply_strb(regs.mtime[31:0], reg_wr_data, reg_wr_strb);
        MTIMER_MTIME_HI:
          regs_nxt.mtime[63:32] = apply_strb(regs.mtime[63:32], reg_wr_data, reg_wr_strb);
        MTIMER_MTIMECMP_LO:
          regs_nxt.mtimecmp[31:0] = apply_strb(regs.mtimecmp[31:0], reg_wr_data, reg_wr_strb);
        MTIMER_MTIMECMP_HI:
          regs_nxt.mtimecmp[63:32] = apply_strb(regs.mtimecmp[63:32], reg_wr_data, reg_wr_strb);
        MTIMER_CTRL:
          regs_nxt.en = reg_wr_strb[0] ? reg_wr_data[0] : regs.en;
        MTIMER_PRESCALE:
          regs_nxt.prescale = apply_strb(regs.prescale, reg_wr_data, reg_wr_strb) & PRESCALE_MASK;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      regs.mtime    <= '0;
      regs.mtimecmp <= MTIMECMP_RST;
      regs.en       <= 1'b0;
      regs.prescale <= '0;
      pcnt          <= '0;
      irq           <= 1'b0;
    end else begin
      regs <= regs_nxt;
      if (regs.en) pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
      irq <= regs.en && (regs.mtime >= regs.mtimecmp);
    end
  end

  always_comb begin
    reg_rd_data = '0;
    case (reg_rd_addr)
      MTIMER_MTIME_LO:    reg_rd_data = regs.mtime[31:0];
      MTIMER_MTIME_HI:    reg_rd_data = regs.mtime[63:32];
      MTIMER_MTIMECMP_LO: reg_rd_data = regs.mtimecmp[31:0];
      MTIMER_MTIMECMP_HI: reg_rd_data = regs.mtimecmp[63:32];
      MTIMER_CTRL:        reg_rd_data = {31'd0, regs.en};
      MTIMER_PRESCALE:    reg_rd_data = regs.prescale;
      default:            reg_rd_data = '0;
    endcase
  end

  assign timer_irq_o = irq;

endmodule
`default_nettype wire

// File: tb/tb_axi_mtimer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_mtimer: self-checking bench for axi_mtimer                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_axi_mtimer;
  import ravenoc_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_edge = 0;
  int last_ar_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_mtimer #(.PRESCALE_W(16), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk         (clk),
    .arst        (arst),
    .axi_mosi    (mosi),
    .axi_miso    (miso),
    .timer_irq_o (irq)
  );

  typedef struct {logic [3:0] id; axi_resp_t resp;} b_exp_t;
  typedef struct {logic [3:0] id; logic [31:0] data; axi_resp_t resp; logic last;} r_exp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
                  axi_resp_t resp; logic [31:0] rdata;} vec_t;
  b_exp_t bq[$];
  r_exp_t rq[$];
  vec_t   vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_b();
    b_exp_t e;
    int guard = 0;
    mosi.bready = 1'b1;
    do begin @(negedge clk); guard++; end while (!miso.bvalid && guard < 64);
    e = bq.pop_front();
    check("bvalid", miso.bvalid, 1);
    check("bid", miso.bid, e.id);
    check("bresp", miso.bresp, e.resp);
    @(posedge clk); #1;
    mosi.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id,
                           input logic [7:0] len, input axi_resp_t exp);
    bit aw_done, w_done, aw_hs, w_hs;
    int beats, guard;
    aw_done = 0; w_done = 0; beats = 0; guard = 0;
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len; mosi.awvalid = 1'b1;
    mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = (len == 8'd0); mosi.wvalid = 1'b1;
    bq.push_back('{id, exp});
    while (!(aw_done && w_done) && guard < 64) begin
      @(negedge clk);
      aw_hs = mosi.awvalid && miso.awready;
      w_hs  = mosi.wvalid && miso.wready;
      if (aw_hs || w_hs) upd_edge = cyc + 2;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; mosi.awvalid = 1'b0; end
      if (w_hs) begin
        if (mosi.wlast) begin w_done = 1; mosi.wvalid = 1'b0; end
        else begin beats++; mosi.wlast = (beats == int'(len)); end
      end
      guard++;
    end
    if (!aw_done) check("aw_timeout", miso.awready, 1);
    if (!w_done) check("w_timeout", miso.wready, 1);
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    wait_b();
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int guard = 0;
    bit done = 0;
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = len; mosi.arvalid = 1'b1;
    while (!done && guard < 64) begin
      @(negedge clk);
      if (miso.arready) begin done = 1; last_ar_edge = cyc + 1; end
      @(posedge clk); #1;
      guard++;
    end
    mosi.arvalid = 1'b0;
    if (!done) check("ar_timeout", miso.arready, 1);
  endtask

  task automatic r_collect();
    r_exp_t e;
    int guard;
    mosi.rready = 1'b1;
    while (rq.size() > 0) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (!miso.rvalid && guard < 64);
      e = rq.pop_front();
      check("rvalid", miso.rvalid, 1);
      check("rid", miso.rid, e.id);
      check("rdata", miso.rdata, e.data);
      check("rresp", miso.rresp, e.resp);
      check("rlast", miso.rlast, e.last);
      @(posedge clk); #1;
    end
    mosi.rready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input axi_resp_t resp, input logic [31:0] data);
    ar_issue(addr, id, len);
    for (int i = 0; i <= int'(len); i++) rq.push_back('{id, data, resp, i == int'(len)});
    r_collect();
  endtask

  task automatic add_vec(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input axi_resp_t resp, input logic [31:0] rdata);
    vecs.push_back('{wr, addr, data, strb, resp, rdata});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e_edge, u_edge, guard;
    logic [63:0] v;

    add_vec(0, 32'h08, 0, 0, OKAY, 32'hFFFF_FFFF);
    add_vec(0, 32'h0C, 0, 0, OKAY, 32'hFFFF_FFFF);
    add_vec(0, 32'h00, 0, 0, OKAY, 32'h0);
    add_vec(0, 32'h04, 0, 0, OKAY, 32'h0);
    add_vec(0, 32'h10, 0, 0, OKAY, 32'h0);
    add_vec(0, 32'h14, 0, 0, OKAY, 32'h0);
    add_vec(0, 32'h18, 0, 0, SLVERR, 32'h0);
    add_vec(0, 32'h02, 0, 0, SLVERR, 32'h0);
    add_vec(1, 32'h14, 32'h1234_ABCD, 4'hF, OKAY, 0);
    add_vec(0, 32'h14, 0, 0, OKAY, 32'h0000_ABCD);
    add_vec(1, 32'h14, 32'h0000_00EF, 4'h1, OKAY, 0);
    add_vec(0, 32'h14, 0, 0, OKAY, 32'h0000_ABEF);
    add_vec(1, 32'h08, 32'hDEAD_BEEF, 4'hF, OKAY, 0);
    add_vec(0, 32'h08, 0, 0, OKAY, 32'hDEAD_BEEF);
    add_vec(1, 32'h1C, 32'h1111_1111, 4'hF, SLVERR, 0);
    add_vec(1, 32'h0A, 32'h2222_2222, 4'hF, SLVERR, 0);
    add_vec(0, 32'h08, 0, 0, OKAY, 32'hDEAD_BEEF);
    add_vec(1, 32'h10, 32'hFFFF_FFFE, 4'hF, OKAY, 0);
    add_vec(0, 32'h10, 0, 0, OKAY, 32'h0);
    add_vec(1, 32'h04, 32'hA5A5_FFFF, 4'hC, OKAY, 0);
    add_vec(0, 32'h04, 0, 0, OKAY, 32'hA5A5_0000);
    add_vec(1, 32'h04, 32'h0, 4'hF, OKAY, 0);
    add_vec(1, 32'h14, 32'h0, 4'hF, OKAY, 0);
    add_vec(1, 32'h08, 32'hA, 4'hF, OKAY, 0);
    add_vec(1, 32'h0C, 32'h0, 4'hF, OKAY, 0);
    add_vec(0, 32'h0C, 0, 0, OKAY, 32'h0);
    add_vec(0, 32'h08, 0, 0, OKAY, 32'hA);

    mosi = '0;
    arst = 1'b1;
    repeat (4) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    check("rst_irq", irq, 0);
    check("rst_awready", miso.awready, 1);
    check("rst_wready", miso.wready, 1);
    check("rst_arready", miso.arready, 1);
    check("rst_bvalid", miso.bvalid, 0);
    check("rst_rvalid", miso.rvalid, 0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 4'(i), 8'd0, vecs[i].resp);
      else axi_read(vecs[i].addr, 4'(i), 8'd0, vecs[i].resp, vecs[i].rdata);
    end
    @(negedge clk);
    check("irq_disabled", irq, 0);
    @(posedge clk); #1;

    // prescale 0: mtime counts every cycle, irq one cycle after mtime hits 10
    axi_write(32'h10, 32'h1, 4'hF, 4'h1, 8'd0, OKAY);
    e_edge = upd_edge;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("irq_timing", irq, (cyc >= e_edge + 11) ? 1 : 0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      repeat (k + 1) @(posedge clk);
      #1;
      ar_issue(32'h00, 4'h2, 8'd0);
      rq.push_back('{4'h2, 32'(last_ar_edge - 1 - e_edge), OKAY, 1'b1});
      r_collect();
    end
    axi_read(32'h04, 4'h3, 8'd0, OKAY, 32'h0);
    axi_write(32'h10, 32'h0, 4'hF, 4'h4, 8'd0, OKAY);

    // prescale 3: one tick every 4 cycles, then lo->hi carry
    axi_write(32'h00, 32'h0, 4'hF, 4'h5, 8'd0, OKAY);
    axi_write(32'h04, 32'h0, 4'hF, 4'h5, 8'd0, OKAY);
    axi_write(32'h14, 32'h3, 4'hF, 4'h6, 8'd0, OKAY);
    axi_write(32'h10, 32'h1, 4'hF, 4'h7, 8'd0, OKAY);
    e_edge = upd_edge;
    for (int k = 0; k < 4; k++) begin
      repeat (3 * k + 1) @(posedge clk);
      #1;
      ar_issue(32'h00, 4'h8, 8'd0);
      rq.push_back('{4'h8, 32'((last_ar_edge - 1 - e_edge) / 4), OKAY, 1'b1});
      r_collect();
    end
    axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 4'h9, 8'd0, OKAY);
    u_edge = upd_edge;
    repeat (10) @(posedge clk);
    #1;
    ar_issue(32'h04, 4'hA, 8'd0);
    v = 64'h0000_0000_FFFF_FFFF + 64'((last_ar_edge - 1 - e_edge) / 4 - (u_edge - e_edge) / 4);
    rq.push_back('{4'hA, v[63:32], OKAY, 1'b1});
    r_collect();
    ar_issue(32'h00, 4'hB, 8'd0);
    v = 64'h0000_0000_FFFF_FFFF + 64'((last_ar_edge - 1 - e_edge) / 4 - (u_edge - e_edge) / 4);
    rq.push_back('{4'hB, v[31:0], OKAY, 1'b1});
    r_collect();
    axi_write(32'h10, 32'h0, 4'hF, 4'hC, 8'd0, OKAY);
    axi_write(32'h14, 32'h0, 4'hF, 4'hC, 8'd0, OKAY);

    // burst write is drained and rejected; burst read gives all-SLVERR beats
    axi_write(32'h00, 32'h1234, 4'hF, 4'hD, 8'd0, OKAY);
    axi_write(32'h00, 32'hFFFF, 4'hF, 4'hE, 8'd2, SLVERR);
    axi_read(32'h00, 4'hE, 8'd0, OKAY, 32'h1234);
    axi_read(32'h00, 4'h6, 8'd3, SLVERR, 32'h0);
    axi_write(32'h1C, 32'h5555, 4'hF, 4'h2, 8'd0, SLVERR);
    axi_read(32'h00, 4'h2, 8'd0, OKAY, 32'h1234);
    axi_read(32'h14, 4'h2, 8'd0, OKAY, 32'h0);

    // W leads AW by 3 cycles, then B held off for 5 cycles
    mosi.wdata = 32'h77; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    @(negedge clk);
    check("w_first_wready", miso.wready, 1);
    @(posedge clk); #1;
    mosi.wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wready_held_low", miso.wready, 0);
      check("bvalid_no_aw", miso.bvalid, 0);
      @(posedge clk); #1;
    end
    mosi.awid = 4'h9; mosi.awaddr = 32'h14; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    bq.push_back('{4'h9, OKAY});
    @(negedge clk);
    check("aw_late_awready", miso.awready, 1);
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!miso.bvalid && guard < 20);
    for (int k = 0; k < 5; k++) begin
      check("b_stall_bvalid", miso.bvalid, 1);
      check("b_stall_bid", miso.bid, bq[0].id);
      check("b_stall_bresp", miso.bresp, bq[0].resp);
      @(posedge clk); #1;
      if (k < 4) @(negedge clk);
    end
    wait_b();
    @(negedge clk);
    check("ready_back_aw", miso.awready, 1);
    check("ready_back_w", miso.wready, 1);
    @(posedge clk); #1;
    axi_read(32'h14, 4'h1, 8'd0, OKAY, 32'h77);

    // reset with bvalid pending and a read response outstanding
    axi_write(32'h10, 32'h1, 4'hF, 4'h3, 8'd0, OKAY);
    mosi.awid = 4'h4; mosi.awaddr = 32'h14; mosi.awlen = 8'd0; mosi.awvalid = 1'b1;
    mosi.wdata = 32'h5; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    @(posedge clk); #1;
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    mosi.arid = 4'h5; mosi.araddr = 32'h00; mosi.arlen = 8'd0; mosi.arvalid = 1'b1;
    @(posedge clk); #1;
    mosi.arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", miso.bvalid, 1);
    check("pre_rst_rvalid", miso.rvalid, 1);
    check("pre_rst_irq", irq, 1);
    @(posedge clk); #1;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    check("abort_bvalid", miso.bvalid, 0);
    check("abort_rvalid", miso.rvalid, 0);
    check("abort_awready", miso.awready, 1);
    check("abort_wready", miso.wready, 1);
    check("abort_arready", miso.arready, 1);
    check("abort_irq", irq, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_b", miso.bvalid, 0);
    end
    @(posedge clk); #1;
    axi_read(32'h00, 4'h6, 8'd0, OKAY, 32'h0);
    axi_read(32'h14, 4'h6, 8'd0, OKAY, 32'h0);
    axi_read(32'h0C, 4'h7, 8'd0, OKAY, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_mtimer.md
Name: axi_mtimer

Overview:
- AXI4 slave peripheral on the core's D-bus, downstream of the core wrapper on the data path.
- Implements a RISC-V machine timer: 64-bit mtime, 64-bit mtimecmp, prescaler, enable.
- Drives the level-sensitive timer interrupt line into the core's timerInterrupt input.
- Single-beat accesses only; bursts are drained and answered with SLVERR.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and counter.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, chosen so no IRQ fires after reset.

Ports:
- clk  input  1  system clock
- arst  input  1  reset: synchronous, active-high
- axi_mosi  input  s_axi_mosi_t  AXI4 request channels from the D-bus (ravenoc_pkg)
- axi_miso  output  s_axi_miso_t  AXI4 response channels to the D-bus
- timer_irq_o  output  1  level interrupt: en && (mtime >= mtimecmp)

Behaviour:
- Register map, byte offset = addr[4:0], word aligned:
  - 0x00 mtime_lo (RW)
  - 0x04 mtime_hi (RW)
  - 0x08 mtimecmp_lo (RW)
  - 0x0C mtimecmp_hi (RW)
  - 0x10 ctrl (bit0 en, RW; other bits read 0)
  - 0x14 prescale (RW, PRESCALE_W LSBs)
  - 0x18 and above: unmapped.
- Reset values:
  - mtime = 0, mtimecmp = MTIMECMP_RST, en = 0, prescale = 0, prescale counter = 0, timer_irq_o = 0.
  - All *valid outputs = 0; awready = wready = arready = 1.
- Tick: when en = 1, the prescale counter increments each cycle. When it equals prescale, the counter clears and mtime += 1 (64-bit, wraps to 0). prescale = 0 therefore gives +1 every cycle.
- timer_irq_o is registered: it updates one cycle after mtime, mtimecmp or en change.
- Write channel:
  - AW and W are captured independently into holding registers, in either order or in the same cycle.
  - awready drops while an AW is held; wready drops while a W is held.
  - Once both are held, the register update happens in that cycle. bvalid rises the next cycle, with bid = awid.
  - bvalid is held with a stable payload until bready. Both holds clear on the B handshake; ready re-asserts the following cycle.
- Write strobes: wstrb applies byte-wise; awsize is ignored.
- Write errors (no register update, bresp = SLVERR): awlen != 0, awaddr[1:0] != 0, or an unmapped offset.
- Bursts on write (awlen != 0): wready stays high until the beat with wlast is accepted, then a single B response is issued.
- Write vs tick collision: a software write to an mtime half wins over the tick in the same cycle for that half. A carry from lo into the unwritten hi half is still applied.
- Read channel:
  - arready = 1 while R is idle. On the AR handshake, arready drops; rvalid rises the next cycle with rid = arid and rdata = register value sampled at the AR handshake.
  - rlast = 1 for single beats. rvalid and the payload are held until rready.
- Read errors: arlen != 0 returns arlen+1 beats, all SLVERR with rdata = 0, rlast on the final beat. Misaligned or unmapped reads return a single beat with SLVERR and rdata = 0.
- Read and write paths are fully independent and may complete in the same cycle.
- Reset asserted mid-transaction: all holds, pending responses and burst counters are discarded. Outputs return to reset values in the next cycle. No response is issued for aborted transfers.

Decomposition:
- ravenoc_pkg gets:
  - MTIMER_* offset localparams
  - axi_resp enum entries OKAY and SLVERR, if not already present
  - a mtimer_regs_t struct (mtime, mtimecmp, en, prescale).
- Natural sub-module: axi_slave_if. It handles AW/W capture, B/R sequencing, burst drain and error responses. It exposes a simple reg_wr(addr, data, strb) / reg_rd(addr) to axi_mtimer, which keeps the timer datapath and interrupt.

Test Plan:
- Reset, then read 0x08 and 0x0C -> OKAY, rdata 32'hFFFF_FFFF both; timer_irq_o = 0; read 0x00 -> 0.
- Write prescale = 0, mtimecmp = 10, ctrl = 1 -> mtime reads increase by 1 per cycle; timer_irq_o rises exactly one cycle after mtime reaches 10.
- Write prescale = 3, en = 1 -> mtime increments once every 4 cycles. Write mtime_lo = 32'hFFFF_FFFF -> hi increments on the next tick.
- W beat presented 3 cycles before AW, then AW with bready held low for 5 cycles -> single B, OKAY, bid echoed, bvalid stable for all 5 cycles.
- Read with arlen = 3 -> 4 R beats, all SLVERR with rdata 0, rlast only on beat 4. Write to 0x1C -> SLVERR, no register changes.
- Reset asserted while bvalid = 1 and an AR is in flight -> next cycle bvalid = rvalid = 0, readies = 1, mtime = 0.
